// File: rtl/core_branch_pred_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Contents:
//   bt_type_e     branch type encoding: 00 COND, 01 JUMP, 10 CALL, 11 RET.
//   PHT_RESET     reset value of every PHT 2-bit counter (weakly not-taken).
//   Default parameter values for BTB, PHT and RAS sizing.
//   pht_next()    saturating 2-bit counter update, clamped to 0..3.
package core_branch_pred_pkg;

  typedef enum logic [1:0] {
    BT_COND = 2'b00,
    BT_JUMP = 2'b01,
    BT_CALL = 2'b10,
    BT_RET  = 2'b11
  } bt_type_e;

  localparam logic [1:0] PHT_RESET = 2'b01;

  localparam int BTB_IDX_BITS_DEF = 4;
  localparam int PHT_PC_BITS_DEF  = 4;
  localparam int RAS_DEPTH_DEF    = 4;

  // Saturating counter step: +1 when taken, -1 when not taken.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/core_branch_pred_if.sv
// Interface between the fetch/execute pipeline and the branch predictor.
// Signals:
//   pc, fetch_en                      lookup request from fetch
//   pred_taken, pred_target           next-PC prediction
//   delayed_PHT, delayed_BHR,
//   btb_type, btb_v                   prediction metadata latched into IF/ID
//   upd_v, upd_pc, upd_taken,
//   upd_target, upd_type,
//   upd_PHT, upd_BHR                  resolved-branch update from EX
// Modports:
//   master  pipeline side (drives lookup and update, receives prediction)
//   slave   predictor side
interface core_branch_pred_if;

  logic [31:0] pc;
  logic        fetch_en;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  delayed_PHT;
  logic [2:0]  delayed_BHR;
  logic [1:0]  btb_type;
  logic        btb_v;
  logic        upd_v;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_type;
  logic [1:0]  upd_PHT;
  logic [2:0]  upd_BHR;

  modport master (
    output pc, fetch_en,
    output upd_v, upd_pc, upd_taken, upd_target, upd_type, upd_PHT, upd_BHR,
    input  pred_taken, pred_target, delayed_PHT, delayed_BHR, btb_type, btb_v
  );

  modport slave (
    input  pc, fetch_en,
    input  upd_v, upd_pc, upd_taken, upd_target, upd_type, upd_PHT, upd_BHR,
    output pred_taken, pred_target, delayed_PHT, delayed_BHR, btb_type, btb_v
  );

endinterface

// File: rtl/core_branch_pred_ras.sv
// core_ras: speculative return address stack built as a circular buffer.
// A push while full overwrites the oldest entry; a pop while empty does nothing.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears count and pointer)
//   push        write push_data on top
//   pop         discard top entry
//   push_data   return address to push
//   top         current top of stack (meaningless when empty)
//   empty       no valid entries
module core_ras #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // ptr_r is the next free slot; top lives one slot below it.
  logic [PTR_W-1:0] ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr_s;

  assign top_ptr_s = ptr_r - PTR_W'(1);
  assign top       = mem_r[top_ptr_s];
  assign empty     = (count_r == CNT_W'(0));

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else if (push) begin
      ptr_r <= ptr_r + PTR_W'(1);
      if (count_r != CNT_W'(RAS_DEPTH)) begin
        count_r <= count_r + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr_r   <= ptr_r - PTR_W'(1);
      count_r <= count_r - CNT_W'(1);
    end
  end

  // Stack storage; contents need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_r[ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/core_branch_pred.sv
// core_branch_pred: fetch-stage branch predictor.
//   Direct-mapped BTB, gshare-style PHT of 2-bit counters indexed by
//   {pc bits, 3-bit global BHR}, and a speculative return address stack.
//   Lookup is combinational from bp.pc; updates from EX take effect next cycle
//   and are not bypassed to a same-cycle lookup.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (clears BTB valid, PHT, BHR, RAS)
//   bp    core_branch_pred_if.slave: lookup, prediction and update signals
module core_branch_pred
  import core_branch_pred_pkg::*;
#(
  parameter int BTB_IDX_BITS = BTB_IDX_BITS_DEF,
  parameter int PHT_PC_BITS  = PHT_PC_BITS_DEF,
  parameter int RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  core_branch_pred_if.slave bp
);

  localparam int BTB_N     = 1 << BTB_IDX_BITS;
  localparam int TAG_W     = 30 - BTB_IDX_BITS;
  localparam int PHT_IDX_W = PHT_PC_BITS + 3;
  localparam int PHT_N     = 1 << PHT_IDX_W;

  // Predictor state.
  logic [BTB_N-1:0] btb_valid_r;
  logic [TAG_W-1:0] btb_tag_r    [BTB_N];
  logic [31:0]      btb_target_r [BTB_N];
  bt_type_e         btb_type_r   [BTB_N];
  logic [1:0]       pht_r        [PHT_N];
  logic [2:0]       bhr_r;

  // Lookup path.
  logic [BTB_IDX_BITS-1:0] lk_idx_s;
  logic [TAG_W-1:0]        lk_tag_s;
  logic                    hit_s;
  bt_type_e                hit_type_s;
  logic [PHT_IDX_W-1:0]    lk_pht_idx_s;
  logic [1:0]              lk_cnt_s;
  logic [31:0]             pc_plus4_s;
  logic                    pred_taken_s;
  logic [31:0]             pred_target_s;

  // Update path.
  logic [BTB_IDX_BITS-1:0] up_idx_s;
  logic [TAG_W-1:0]        up_tag_s;
  logic [PHT_IDX_W-1:0]    up_pht_idx_s;
  logic                    up_cond_s;
  logic                    up_btb_we_s;
  logic                    unused_upd_pc_lo_s;

  // RAS hookup.
  logic        ras_push_s;
  logic        ras_pop_s;
  logic [31:0] ras_top_s;
  logic        ras_empty_s;

  assign lk_idx_s     = bp.pc[BTB_IDX_BITS+1:2];
  assign lk_tag_s     = bp.pc[31:BTB_IDX_BITS+2];
  assign hit_s        = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
  assign hit_type_s   = hit_s ? btb_type_r[lk_idx_s] : BT_COND;
  assign lk_pht_idx_s = {bp.pc[PHT_PC_BITS+1:2], bhr_r};
  assign lk_cnt_s     = pht_r[lk_pht_idx_s];
  assign pc_plus4_s   = bp.pc + 32'd4;

  // Direction and target selection from the BTB hit type.
  always_comb begin
    pred_taken_s  = 1'b0;
    pred_target_s = pc_plus4_s;
    if (hit_s) begin
      case (hit_type_s)
        BT_COND: begin
          pred_taken_s  = lk_cnt_s[1];
          pred_target_s = lk_cnt_s[1] ? btb_target_r[lk_idx_s] : pc_plus4_s;
        end
        BT_JUMP, BT_CALL: begin
          pred_taken_s  = 1'b1;
          pred_target_s = btb_target_r[lk_idx_s];
        end
        BT_RET: begin
          // An empty stack falls back to whatever target the BTB learned.
          pred_taken_s  = 1'b1;
          pred_target_s = ras_empty_s ? btb_target_r[lk_idx_s] : ras_top_s;
        end
        default: begin
          pred_taken_s  = 1'b0;
          pred_target_s = pc_plus4_s;
        end
      endcase
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = pc_plus4_s;
    end
  end

  assign bp.pred_taken  = pred_taken_s;
  assign bp.pred_target = pred_target_s;
  assign bp.delayed_PHT = lk_cnt_s;
  assign bp.delayed_BHR = bhr_r;
  assign bp.btb_type    = hit_type_s;
  assign bp.btb_v       = hit_s;

  // The stack moves only on fetches that actually advance past a BTB hit.
  assign ras_push_s = bp.fetch_en && hit_s && (hit_type_s == BT_CALL);
  assign ras_pop_s  = bp.fetch_en && hit_s && (hit_type_s == BT_RET);

  core_ras #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (pc_plus4_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  assign up_idx_s           = bp.upd_pc[BTB_IDX_BITS+1:2];
  assign up_tag_s           = bp.upd_pc[31:BTB_IDX_BITS+2];
  assign up_pht_idx_s       = {bp.upd_pc[PHT_PC_BITS+1:2], bp.upd_BHR};
  assign up_cond_s          = bp.upd_v && (bp.upd_type == BT_COND);
  assign up_btb_we_s        = bp.upd_v && bp.upd_taken;
  assign unused_upd_pc_lo_s = ^bp.upd_pc[1:0];

  // Valid bits, PHT counters and global history; all reset, rst wins over updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_r <= '0;
      for (int i = 0; i < PHT_N; i++) begin
        pht_r[i] <= PHT_RESET;
      end
      bhr_r <= 3'b000;
    end else begin
      if (up_cond_s) begin
        pht_r[up_pht_idx_s] <= pht_next(bp.upd_PHT, bp.upd_taken);
        bhr_r               <= {bhr_r[1:0], bp.upd_taken};
      end
      if (up_btb_we_s) begin
        btb_valid_r[up_idx_s] <= 1'b1;
      end
    end
  end

  // BTB payload arrays; unreset since the valid bit qualifies every read.
  always_ff @(posedge clk) begin
    if (!rst && up_btb_we_s) begin
      btb_tag_r[up_idx_s]    <= up_tag_s;
      btb_target_r[up_idx_s] <= bp.upd_target;
      btb_type_r[up_idx_s]   <= bt_type_e'(bp.upd_type);
    end
  end

endmodule

// File: tb/tb_core_branch_pred.sv
// Self-checking bench for core_branch_pred: a cycle-by-cycle vector table
// covering BTB/PHT/BHR behaviour and basic RAS push/pop, followed by hand
// sequences for RAS overflow and reset overriding a concurrent update.
module tb_core_branch_pred;
  import core_branch_pred_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  core_branch_pred_if bp_if ();

  core_branch_pred #(
    .BTB_IDX_BITS (4),
    .PHT_PC_BITS  (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fe;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic [1:0]  uty;
    logic [1:0]  uph;
    logic [2:0]  ubh;
    logic        ev;
    logic [1:0]  ety;
    logic        et;
    logic [31:0] etg;
    logic [1:0]  eph;
    logic [2:0]  ebh;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] pc, input logic fe,
    input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
    input logic [1:0] uty, input logic [1:0] uph, input logic [2:0] ubh,
    input logic ev, input logic [1:0] ety, input logic et, input logic [31:0] etg,
    input logic [1:0] eph, input logic [2:0] ebh);
    vec_t v;
    v.pc = pc; v.fe = fe; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.uty = uty; v.uph = uph; v.ubh = ubh;
    v.ev = ev; v.ety = ety; v.et = et; v.etg = etg; v.eph = eph; v.ebh = ebh;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bp_if.pc         = v.pc;
    bp_if.fetch_en   = v.fe;
    bp_if.upd_v      = v.uv;
    bp_if.upd_pc     = v.upc;
    bp_if.upd_taken  = v.ut;
    bp_if.upd_target = v.utg;
    bp_if.upd_type   = v.uty;
    bp_if.upd_PHT    = v.uph;
    bp_if.upd_BHR    = v.ubh;
  endtask

  // One cycle: drive, check every output at the falling edge, then advance.
  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    chk({tag, ".btb_v"},       {31'd0, bp_if.btb_v},      {31'd0, v.ev});
    chk({tag, ".btb_type"},    {30'd0, bp_if.btb_type},   {30'd0, v.ety});
    chk({tag, ".pred_taken"},  {31'd0, bp_if.pred_taken}, {31'd0, v.et});
    chk({tag, ".pred_target"}, bp_if.pred_target,         v.etg);
    chk({tag, ".delayed_PHT"}, {30'd0, bp_if.delayed_PHT}, {30'd0, v.eph});
    chk({tag, ".delayed_BHR"}, {29'd0, bp_if.delayed_BHR}, {29'd0, v.ebh});
    @(posedge clk);
    #1;
  endtask

  // Lookup only; checks direction and target.
  task automatic look(input string tag, input logic [31:0] p, input logic fe,
                      input logic et, input logic [31:0] etg);
    drive(mk(p, fe, 1'b0, 32'd0, 1'b0, 32'd0, 2'b00, 2'b00, 3'b000,
             1'b0, 2'b00, 1'b0, 32'd0, 2'b00, 3'b000));
    @(negedge clk);
    chk({tag, ".pred_taken"},  {31'd0, bp_if.pred_taken}, {31'd0, et});
    chk({tag, ".pred_target"}, bp_if.pred_target,         etg);
    @(posedge clk);
    #1;
  endtask

  // Update only, with an idle lookup at pc 0.
  task automatic upd(input logic [31:0] p, input logic [31:0] tg, input logic [1:0] ty);
    drive(mk(32'd0, 1'b0, 1'b1, p, 1'b1, tg, ty, 2'b01, 3'b000,
             1'b0, 2'b00, 1'b0, 32'd0, 2'b00, 3'b000));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        pc           fe    uv    upc          ut    utg          uty    uph    ubh      ev    ety    et    etg          eph    ebh
    vecs.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h104, 2'b01, 3'b000));
    vecs.push_back(mk(32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 32'h104, 2'b01, 3'b000));
    vecs.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b0, 32'h104, 2'b01, 3'b001));
    vecs.push_back(mk(32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 2'b00, 2'b01, 3'b001, 1'b1, 2'b00, 1'b0, 32'h104, 2'b01, 3'b001));
    vecs.push_back(mk(32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 2'b00, 2'b10, 3'b001, 1'b1, 2'b00, 1'b0, 32'h104, 2'b01, 3'b011));
    vecs.push_back(mk(32'h100, 1'b0, 1'b1, 32'h1C4, 1'b1, 32'h240, 2'b00, 2'b11, 3'b000, 1'b1, 2'b00, 1'b0, 32'h104, 2'b01, 3'b111));
    vecs.push_back(mk(32'h1C4, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b0, 32'h1C8, 2'b01, 3'b111));
    vecs.push_back(mk(32'h108, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   2'b00, 2'b01, 3'b011, 1'b0, 2'b00, 1'b0, 32'h10C, 2'b01, 3'b110));
    vecs.push_back(mk(32'h108, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   2'b00, 2'b01, 3'b101, 1'b0, 2'b00, 1'b0, 32'h10C, 2'b01, 3'b100));
    vecs.push_back(mk(32'h1C4, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b1, 32'h240, 2'b11, 3'b000));
    vecs.push_back(mk(32'h108, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h10C, 2'b00, 3'b000));
    vecs.push_back(mk(32'h1C4, 1'b0, 1'b1, 32'h1C4, 1'b0, 32'h0,   2'b00, 2'b11, 3'b000, 1'b1, 2'b00, 1'b1, 32'h240, 2'b11, 3'b000));
    vecs.push_back(mk(32'h1C4, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b1, 32'h240, 2'b10, 3'b000));
    vecs.push_back(mk(32'h108, 1'b0, 1'b1, 32'h108, 1'b1, 32'h180, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h10C, 2'b00, 3'b000));
    vecs.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b1, 32'h200, 2'b11, 3'b001));
    vecs.push_back(mk(32'h100, 1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 2'b10, 2'b01, 3'b000, 1'b1, 2'b00, 1'b1, 32'h200, 2'b11, 3'b001));
    vecs.push_back(mk(32'h300, 1'b1, 1'b1, 32'h508, 1'b1, 32'h600, 2'b11, 2'b01, 3'b000, 1'b1, 2'b10, 1'b1, 32'h400, 2'b11, 3'b001));
    vecs.push_back(mk(32'h508, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1, 32'h304, 2'b01, 3'b001));
    vecs.push_back(mk(32'h508, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1, 32'h600, 2'b01, 3'b001));
    vecs.push_back(mk(32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b10, 1'b1, 32'h400, 2'b11, 3'b001));
    vecs.push_back(mk(32'h508, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1, 32'h600, 2'b01, 3'b001));
    vecs.push_back(mk(32'h300, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b10, 1'b1, 32'h400, 2'b11, 3'b001));
    vecs.push_back(mk(32'h508, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1, 32'h304, 2'b01, 3'b001));
    vecs.push_back(mk(32'h508, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1, 32'h304, 2'b01, 3'b001));
    vecs.push_back(mk(32'h508, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1, 32'h600, 2'b01, 3'b001));
    vecs.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h104, 2'b11, 3'b001));
    vecs.push_back(mk(32'h100, 1'b0, 1'b1, 32'h1C4, 1'b1, 32'h280, 2'b01, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 32'h104, 2'b11, 3'b001));
    vecs.push_back(mk(32'h1C4, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 2'b00, 3'b000, 1'b1, 2'b01, 1'b1, 32'h280, 2'b01, 3'b001));

    // After reset: prior entries gone, counters and history back to reset values, pc+4 wraps.
    post.push_back(mk(32'h900,      1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h904, 2'b01, 3'b000));
    post.push_back(mk(32'h300,      1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h304, 2'b01, 3'b000));
    post.push_back(mk(32'h100,      1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h104, 2'b01, 3'b000));
    post.push_back(mk(32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h0,   2'b01, 3'b000));

    rst = 1'b1;
    drive(mk(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 2'b00, 3'b000,
             1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 3'b000));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Five calls into a four-deep stack, then five returns.
    upd(32'h704, 32'h800, 2'b10);
    upd(32'h70C, 32'h800, 2'b10);
    upd(32'h710, 32'h800, 2'b10);
    upd(32'h714, 32'h800, 2'b10);
    upd(32'h718, 32'h800, 2'b10);
    look("call0", 32'h704, 1'b1, 1'b1, 32'h800);
    look("call1", 32'h70C, 1'b1, 1'b1, 32'h800);
    look("call2", 32'h710, 1'b1, 1'b1, 32'h800);
    look("call3", 32'h714, 1'b1, 1'b1, 32'h800);
    look("call4", 32'h718, 1'b1, 1'b1, 32'h800);
    look("ret0",  32'h508, 1'b1, 1'b1, 32'h71C);
    look("ret1",  32'h508, 1'b1, 1'b1, 32'h718);
    look("ret2",  32'h508, 1'b1, 1'b1, 32'h714);
    look("ret3",  32'h508, 1'b1, 1'b1, 32'h710);
    look("ret4",  32'h508, 1'b1, 1'b1, 32'h600);

    // Reset with a concurrent taken update: nothing may be written.
    rst = 1'b1;
    drive(mk(32'h300, 1'b1, 1'b1, 32'h900, 1'b1, 32'hA00, 2'b00, 2'b01, 3'b000,
             1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 3'b000));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < post.size(); i++) begin
      apply($sformatf("post%0d", i), post[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
